// File: rtl/hdmi_text_pkg.sv
// Shared constants, types and the glyph generator for the text-mode renderer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hdmi_text_pkg;

    localparam int COLS          = 80;
    localparam int ROWS          = 30;
    localparam int WORDS_PER_ROW = 20;
    localparam int VRAM_WORDS    = 600;
    localparam int CTRL_WORD     = 600;
    localparam int GLYPH_W       = 8;
    localparam int GLYPH_H       = 16;
    localparam int PIPE_LAT      = 3;

    // Visible text area in pixels.
    localparam int H_ACTIVE = COLS * GLYPH_W;
    localparam int V_ACTIVE = ROWS * GLYPH_H;

    // Control word colour fields (4 bits each of R, G, B, MSB first).
    localparam int CTRL_FG_MSB = 24;
    localparam int CTRL_FG_LSB = 13;
    localparam int CTRL_BG_MSB = 12;
    localparam int CTRL_BG_LSB = 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    // One character cell as stored in a VRAM byte.
    typedef struct packed {
        logic       inv;
        logic [6:0] code;
    } cell_t;

    // Procedural font: every glyph row is a distinct, fully populated bit
    // pattern. A bitmap ROM can replace it behind the same port.
    function automatic logic [7:0] font_pattern(input logic [6:0] code,
                                                input logic [3:0] row);
        return {code, 1'b0} ^ {row, row};
    endfunction

    // Word address of a character cell: four cells per 32-bit word.
    function automatic logic [9:0] cell_word_addr(input logic [4:0] row,
                                                  input logic [4:0] word_col);
        return 10'(row) * 10'(WORDS_PER_ROW) + 10'(word_col);
    endfunction

endpackage

// File: rtl/font_rom.sv
// Glyph ROM, 2048 x 8: address is {glyph code, glyph row}.
// Latency: 1 clock, registered data, no reset on the data path.
// Backpressure: none; accepts a new address every clock.
module font_rom
    import hdmi_text_pkg::*;
(
    input  logic        i_clk,
    input  logic [10:0] i_addr,
    output logic [7:0]  o_dat
);

    logic [7:0] r_dat;

    // Synchronous read of the glyph row.
    always_ff @(posedge i_clk) begin
        r_dat <= font_pattern(i_addr[10:4], i_addr[3:0]);
    end

    assign o_dat = r_dat;

endmodule

// File: rtl/hdmi_text_renderer.sv
// 80x30 text-mode pixel generator: drawX/drawY -> VRAM cell -> glyph -> RGB.
// Latency: 3 clocks from drawX/drawY/strobes to RGB and delayed strobes.
// Backpressure: none; one VRAM read per clock, never stalls.
module hdmi_text_renderer #(
    parameter int VRAM_AW  = 10,
    parameter int PIPE_LAT = hdmi_text_pkg::PIPE_LAT
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    input  logic [9:0]         drawX,
    input  logic [9:0]         drawY,
    input  logic               hsync_i,
    input  logic               vsync_i,
    input  logic               vde_i,
    output logic [VRAM_AW-1:0] vram_addr,
    input  logic [31:0]        vram_rdata,
    input  logic [31:0]        ctrl,
    output logic [3:0]         red,
    output logic [3:0]         green,
    output logic [3:0]         blue,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               vde_o
);
    import hdmi_text_pkg::*;

    // Stage 0: cell coordinates and VRAM word address.
    logic [6:0] w_col;
    logic [4:0] w_row;
    logic       w_in_text;
    logic [9:0] w_cell_addr;

    assign w_col       = drawX[9:3];
    assign w_row       = drawY[8:4];
    assign w_in_text   = (drawX < 10'(H_ACTIVE)) && (drawY < 10'(V_ACTIVE));
    assign w_cell_addr = cell_word_addr(w_row, w_col[6:2]);

    // Sideband pipeline; stage N registers travel alongside the data path.
    logic [3:0]          r_s1_ylo, r_s2_ylo;
    logic [1:0]          r_s1_col, r_s2_col;
    logic [2:0]          r_s1_xlo, r_s2_xlo, r_s3_xlo;
    logic                r_s3_inv;
    logic [PIPE_LAT-1:0] r_vde_sr, r_hs_sr, r_vs_sr;
    logic [11:0]         r_fg, r_bg;

    // Stage 1: pick the cell byte out of the returned word, address the font.
    cell_t       w_cell;
    logic [10:0] w_font_addr;
    logic [7:0]  w_font_dat;

    assign w_cell      = cell_t'(vram_rdata[{r_s2_col, 3'b000} +: 8]);
    assign w_font_addr = {w_cell.code, r_s2_ylo};

    font_rom u_font_rom (
        .i_clk  (S_AXI_ACLK),
        .i_addr (w_font_addr),
        .o_dat  (w_font_dat)
    );

    // Address register, sideband shift registers and sampled colours.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            vram_addr <= '0;
            r_s1_ylo  <= '0;
            r_s1_col  <= '0;
            r_s1_xlo  <= '0;
            r_s2_ylo  <= '0;
            r_s2_col  <= '0;
            r_s2_xlo  <= '0;
            r_s3_xlo  <= '0;
            r_s3_inv  <= 1'b0;
            r_vde_sr  <= '0;
            r_hs_sr   <= '0;
            r_vs_sr   <= '0;
            r_fg      <= '0;
            r_bg      <= '0;
        end else begin
            // Outside the text area read a harmless fixed word.
            vram_addr <= w_in_text ? VRAM_AW'(w_cell_addr) : '0;
            r_s1_ylo  <= drawY[3:0];
            r_s1_col  <= w_col[1:0];
            r_s1_xlo  <= drawX[2:0];
            r_s2_ylo  <= r_s1_ylo;
            r_s2_col  <= r_s1_col;
            r_s2_xlo  <= r_s1_xlo;
            r_s3_xlo  <= r_s2_xlo;
            r_s3_inv  <= w_cell.inv;
            r_vde_sr  <= {r_vde_sr[PIPE_LAT-2:0], vde_i};
            r_hs_sr   <= {r_hs_sr[PIPE_LAT-2:0], hsync_i};
            r_vs_sr   <= {r_vs_sr[PIPE_LAT-2:0], vsync_i};
            // Colours are captured one clock before the pixel leaves, so a
            // control write shows up on the very next output pixel.
            r_fg      <= ctrl[CTRL_FG_MSB:CTRL_FG_LSB];
            r_bg      <= ctrl[CTRL_BG_MSB:CTRL_BG_LSB];
        end
    end

    // Stage 2: glyph bit (MSB is leftmost), invert, colour select, blanking.
    logic w_pix;
    rgb_t w_rgb;

    assign w_pix = w_font_dat[3'd7 - r_s3_xlo] ^ r_s3_inv;
    assign w_rgb = r_vde_sr[PIPE_LAT-1] ? rgb_t'(w_pix ? r_fg : r_bg) : '0;

    assign red     = w_rgb.r;
    assign green   = w_rgb.g;
    assign blue    = w_rgb.b;
    assign hsync_o = r_hs_sr[PIPE_LAT-1];
    assign vsync_o = r_vs_sr[PIPE_LAT-1];
    assign vde_o   = r_vde_sr[PIPE_LAT-1];

    // Reserved control bits carry no meaning here.
    logic w_ctrl_unused;
    assign w_ctrl_unused = ^{ctrl[31:25], ctrl[0]};

endmodule

// File: tb/tb_hdmi_text_renderer.sv
module tb_hdmi_text_renderer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  drawX = '0;
    logic [9:0]  drawY = '0;
    logic        hs = 1'b0;
    logic        vs = 1'b0;
    logic        vde = 1'b0;
    logic [9:0]  vram_addr;
    logic [31:0] vram_rdata = '0;
    logic [31:0] ctrl = '0;
    logic [3:0]  red, green, blue;
    logic        hs_o, vs_o, vde_o;

    logic [31:0] vram [0:1023];
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hdmi_text_renderer #(.VRAM_AW(10), .PIPE_LAT(3)) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .drawX        (drawX),
        .drawY        (drawY),
        .hsync_i      (hs),
        .vsync_i      (vs),
        .vde_i        (vde),
        .vram_addr    (vram_addr),
        .vram_rdata   (vram_rdata),
        .ctrl         (ctrl),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .hsync_o      (hs_o),
        .vsync_o      (vs_o),
        .vde_o        (vde_o)
    );

    // BRAM read port: one clock of latency.
    always @(posedge clk) vram_rdata <= vram[vram_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: screen rules in plain arithmetic.
    function automatic int word_addr(int x, int y);
        if (x < 640 && y < 480) return (y / 16) * 20 + x / 32;
        return 0;
    endfunction

    function automatic logic [11:0] pixel(int x, int y, logic v, logic [31:0] c);
        int unsigned w, b, code, inv, glyph, bitv;
        if (!v) return 12'h000;
        w     = vram[word_addr(x, y)];
        b     = (w >> (8 * ((x / 8) % 4))) & 255;
        code  = b % 128;
        inv   = b / 128;
        glyph = ((code * 2) ^ ((y % 16) * 17)) % 256;
        bitv  = ((glyph >> (7 - x % 8)) & 1) ^ inv;
        if (bitv == 1) return 12'((c >> 13) & 32'hFFF);
        return 12'((c >> 1) & 32'hFFF);
    endfunction

    // Input history: index 0 = sampled at the latest edge, 2 = three edges ago.
    int          hx [3] = '{0, 0, 0};
    int          hy [3] = '{0, 0, 0};
    logic        hv [3] = '{1'b0, 1'b0, 1'b0};
    logic        hh [3] = '{1'b0, 1'b0, 1'b0};
    logic        hvs[3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] ctrl_q = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                hx[i] <= 0; hy[i] <= 0; hv[i] <= 1'b0; hh[i] <= 1'b0; hvs[i] <= 1'b0;
            end
            ctrl_q <= '0;
        end else begin
            hx[0] <= int'(drawX); hy[0] <= int'(drawY);
            hv[0] <= vde; hh[0] <= hs; hvs[0] <= vs;
            for (int i = 1; i < 3; i++) begin
                hx[i] <= hx[i-1]; hy[i] <= hy[i-1];
                hv[i] <= hv[i-1]; hh[i] <= hh[i-1]; hvs[i] <= hvs[i-1];
            end
            ctrl_q <= ctrl;
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        chk("vram_addr", 32'(vram_addr), 32'(word_addr(hx[0], hy[0])));
        chk("rgb", 32'({red, green, blue}), 32'(pixel(hx[2], hy[2], hv[2], ctrl_q)));
        chk("hsync_o", 32'(hs_o), 32'(hh[2]));
        chk("vsync_o", 32'(vs_o), 32'(hvs[2]));
        chk("vde_o", 32'(vde_o), 32'(hv[2]));
    end

    // Hand-computed pins: address after one edge, pixel after three.
    task automatic lit(input string nm, input int x, input int y,
                       input logic [9:0] exp_addr, input logic [11:0] exp_rgb);
        @(posedge clk); #1;
        drawX = 10'(x); drawY = 10'(y); vde = 1'b1; hs = 1'b0; vs = 1'b0;
        @(posedge clk); #1;
        chk({nm, " addr"}, 32'(vram_addr), 32'(exp_addr));
        @(posedge clk); @(posedge clk); #1;
        chk({nm, " rgb"}, 32'({red, green, blue}), 32'(exp_rgb));
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        vde = 1'b0; hs = 1'b0; vs = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) vram[i] = '0;
        vram[0]   = 32'h0000_0041;
        vram[599] = 32'h4100_0000;
        ctrl      = 32'h01FF_E000;   // fg FFF, bg 000
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Glyph 0x41 row 0 = 0x82; row 15 = 0x7D; code 0 row 10 = 0xAA.
        lit("origin",   0,   0,   10'd0,   12'hFFF);
        lit("x1",       1,   0,   10'd0,   12'h000);
        lit("x6",       6,   0,   10'd0,   12'hFFF);
        lit("corner",   639, 479, 10'd599, 12'hFFF);
        lit("corner0",  632, 479, 10'd599, 12'h000);
        lit("blank700", 700, 10,  10'd0,   12'hFFF);

        idle(4);
        vram[0] = 32'h0000_00C1;
        lit("inv_x0", 0, 0, 10'd0, 12'h000);
        lit("inv_x1", 1, 0, 10'd0, 12'hFFF);
        lit("inv_x6", 6, 0, 10'd0, 12'h000);

        // Foreground switch from F00 to 0F0 lands on the next pixel out.
        idle(4);
        vram[0] = 32'h0000_0041;
        ctrl = 32'h01E0_001E;
        drawX = '0; drawY = '0; vde = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        ctrl = 32'h001E_001E;
        chk("ctrl_old", 32'({red, green, blue}), 32'h0F00);
        @(posedge clk); #1;
        chk("ctrl_new", 32'({red, green, blue}), 32'h00F0);

        // Line scans with random text, vde dropouts, blanking and a reset.
        idle(4);
        for (int i = 0; i < 600; i++) vram[i] = $urandom;
        for (int ln = 0; ln < 3; ln++) begin
            int y;
            y = (ln == 0) ? int'($urandom_range(0, 479)) : (ln == 1 ? 479 : 500);
            for (int x = 0; x < 800; x++) begin
                @(posedge clk); #1;
                drawX = 10'(x); drawY = 10'(y);
                vde = (x < 640 && y < 480) && ($urandom_range(0, 7) != 0);
                hs  = (x >= 656 && x < 752);
                vs  = (y >= 490 && y < 492);
                if (x % 97 == 0) ctrl = $urandom;
                if (ln == 1 && x == 300) begin
                    #2 rst = 1'b1;
                    #1;
                    chk("rst red",   32'(red),   32'h0);
                    chk("rst green", 32'(green), 32'h0);
                    chk("rst blue",  32'(blue),  32'h0);
                    chk("rst hs",    32'(hs_o),  32'h0);
                    chk("rst vs",    32'(vs_o),  32'h0);
                    chk("rst vde",   32'(vde_o), 32'h0);
                    chk("rst addr",  32'(vram_addr), 32'h0);
                    @(posedge clk); @(posedge clk);
                    #3 rst = 1'b0;
                end
            end
        end

        // Fully random pixels, strobes and control words.
        for (int n = 0; n < 1500; n++) begin
            @(posedge clk); #1;
            drawX = 10'($urandom_range(0, 799));
            drawY = 10'($urandom_range(0, 524));
            vde = 1'($urandom);
            hs  = 1'($urandom);
            vs  = 1'($urandom);
            if (n % 50 == 0) ctrl = $urandom;
        end

        idle(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
